fetch_stage_if_id: RTL and testbench
====================================

// Module: fetch_stage_if_id
// PURPOSE
//  Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS core. Directly consumes
//  StallF/StallD/FlushD from hazard_detection_unit and redirects from Decode (branch/jump).
//  It drives a handshaked instruction-memory port with variable wait states and
//  inserts bubbles (NOP, ValidD=0) into Decode while a fetch is pending.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value after reset
//  NOP_INSTR  32'h0000_0000  encoding injected as a bubble (sll $0,$0,0)
// PORTS
//  clk          in   1   single clock, rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  StallF       in   1   hold PCF; discard any response completing this cycle
//  StallD       in   1   hold IF/ID register
//  FlushD       in   1   load a bubble into IF/ID
//  PCSrcD       in   1   branch taken in Decode
//  PCBranchD    in   32  branch target
//  select_jumpD in   1   jump in Decode
//  PCJumpD      in   32  jump target
//  imem_req     out  1   fetch request
//  imem_addr    out  32  fetch address; stable while imem_req=1 && imem_ready=0
//  imem_ready   in   1   response valid this cycle; imem_rdata is sampled at this edge
//  imem_rdata   in   32  instruction word
//  InstrD       out  32  instruction to Decode
//  PCPlus4D     out  32  PC+4 of InstrD
//  ValidD       out  1   InstrD is a real instruction (0 = bubble)
// BEHAVIOUR
//  Reset: PCF=RESET_PC, imem_req=0, imem_addr=RESET_PC, InstrD=NOP_INSTR, PCPlus4D=0, ValidD=0, state=IDLE.
//  FSM:
//   IDLE    -> FETCH unconditionally on first edge after reset release; imem_req=0.
//   FETCH   imem_req=1, imem_addr=req_addr. done = imem_ready && !StallF.
//   DISCARD imem_req=1, imem_addr=req_addr (old). On imem_ready: drop rdata; req_addr<=PCF; ->FETCH.
//  Next PC (when !StallF), priority: select_jumpD > PCSrcD > (done ? PCF+4 : PCF). Wraps mod 2^32.
//  Redirect (jump/branch && !StallF):
//   - in FETCH with imem_ready=1: PCF<=target, req_addr<=target; stay FETCH; response is wrong-path, dropped.
//   - in FETCH with imem_ready=0: PCF<=target; req_addr unchanged; ->DISCARD.
//   - in DISCARD: PCF<=target. If imem_ready=1 this cycle, req_addr<=target and ->FETCH. Otherwise stay DISCARD.
//  Sequential fetch (done, no redirect): PCF<=PCF+4, req_addr<=PCF+4; stay FETCH (back-to-back requests).
//  StallF=1 in FETCH with imem_ready=1: response dropped; same address re-requested (memory is idempotent).
//  IF/ID register, priority StallD > FlushD > load:
//   StallD: hold all three outputs.
//   FlushD: InstrD=NOP_INSTR, ValidD=0, PCPlus4D held.
//   done && no redirect: InstrD=imem_rdata, PCPlus4D=PCF+4, ValidD=1.
//   otherwise: bubble (NOP_INSTR, ValidD=0).
//  Latency: zero-wait memory (ready same cycle as req) gives one instruction per cycle.
//   The instruction appears on InstrD one edge after the completing edge.
//  Precondition: StallD=1 implies StallF=1. The violating combination is flagged by a bench assertion; RTL behaviour for it is undefined.
//  Reset asserted mid-fetch: all state returns to reset values immediately. Any later imem_ready for the old request is ignored because imem_req=0 in IDLE.
// STRUCTURE
//  mips_pkg: NOP_INSTR constant and typedef enum fetch_state_t {IDLE, FETCH, DISCARD}.
//  Sub-module if_id_reg: 32+32+1 register with stall/flush/load priority as above.
//  This top module holds the FSM, PCF, req_addr and next-PC mux.
// TESTING
//  1. Reset release, imem_ready tied 1, words W0..W3 at 0x0..0xC
//     -> imem_addr 0,4,8,C on consecutive cycles; InstrD=W0..W3 back-to-back, ValidD=1, PCPlus4D=4,8,C,10.
//  2. imem_ready delayed 3 cycles per fetch
//     -> imem_addr stable for 3 cycles; ValidD=0 bubbles between instructions; no duplicate or skipped PC.
//  3. select_jumpD=1, PCJumpD=0x100 while fetch outstanding (ready=0)
//     -> DISCARD; old response dropped; next request addr 0x100; wrong-path word never reaches ValidD=1.
//  4. PCSrcD=1 and select_jumpD=1 in the same cycle (0x40 vs 0x80)
//     -> PCF=0x80 (jump wins); FlushD=1 gives InstrD=NOP, ValidD=0.
//  5. StallF=StallD=1 for 2 cycles with ready=1, then StallD=0 and FlushD=1
//     -> PCF and InstrD held for both stall cycles; no PC advance; next edge gives ValidD=0.
//  6. rst_n pulled low mid-DISCARD
//     -> imem_req=0, PCF=RESET_PC, ValidD=0 immediately; fetch restarts at RESET_PC after release.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch front end: bubble encoding and fetch FSM states.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DISCARD
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if_id_if.sv
// Handshaked instruction-memory port between the fetch stage and instruction memory.
interface fetch_stage_if_id_if;

    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  ready,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ready,
        output rdata
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: stall holds everything, flush or no-load inserts a bubble.
module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stallD,
    input  logic        flushD,
    input  logic        load,
    input  logic [31:0] instrF,
    input  logic [31:0] pcPlus4F,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            InstrD   <= NOP_INSTR;
            PCPlus4D <= 32'h0000_0000;
            ValidD   <= 1'b0;
        end else if (stallD) begin
            InstrD   <= InstrD;
            PCPlus4D <= PCPlus4D;
            ValidD   <= ValidD;
        end else if (load && !flushD) begin
            InstrD   <= instrF;
            PCPlus4D <= pcPlus4F;
            ValidD   <= 1'b1;
        end else begin
            // Flush and "nothing fetched" both leave PCPlus4D untouched.
            InstrD   <= NOP_INSTR;
            ValidD   <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage_if_id.sv
// Fetch stage: PC, next-PC mux and request FSM over a wait-state instruction memory,
// feeding the IF/ID register with instructions or bubbles.
module fetch_stage_if_id
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       StallF,
    input  logic                       StallD,
    input  logic                       FlushD,
    input  logic                       PCSrcD,
    input  logic [31:0]                PCBranchD,
    input  logic                       select_jumpD,
    input  logic [31:0]                PCJumpD,
    fetch_stage_if_id_if.master        imem,
    output logic [31:0]                InstrD,
    output logic [31:0]                PCPlus4D,
    output logic                       ValidD
);

    fetch_state_t state, stateNext;
    logic [31:0]  PCF, PCFNext;
    logic [31:0]  reqAddr, reqAddrNext;
    logic [31:0]  pcPlus4F;
    logic [31:0]  target;
    logic         redirect;
    logic         done;

    assign pcPlus4F  = PCF + 32'd4;
    assign imem.addr = reqAddr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            PCF     <= RESET_PC;
            reqAddr <= RESET_PC;
        end else begin
            state   <= stateNext;
            PCF     <= PCFNext;
            reqAddr <= reqAddrNext;
        end
    end

    always_comb begin
        stateNext   = state;
        PCFNext     = PCF;
        reqAddrNext = reqAddr;
        imem.req    = 1'b0;
        done        = 1'b0;
        redirect    = (select_jumpD || PCSrcD) && !StallF;
        target      = select_jumpD ? PCJumpD : PCBranchD;

        unique case (state)
            IDLE: begin
                stateNext = FETCH;
            end
            FETCH: begin
                imem.req = 1'b1;
                done     = imem.ready && !StallF;
                if (redirect) begin
                    PCFNext = target;
                    // The in-flight request is wrong-path: reissue now if it just
                    // completed, otherwise wait it out in DISCARD.
                    if (imem.ready) begin
                        reqAddrNext = target;
                    end else begin
                        stateNext = DISCARD;
                    end
                end else if (done) begin
                    PCFNext     = pcPlus4F;
                    reqAddrNext = pcPlus4F;
                end
            end
            DISCARD: begin
                imem.req = 1'b1;
                if (redirect) begin
                    PCFNext = target;
                end
                if (imem.ready) begin
                    reqAddrNext = PCFNext;
                    stateNext   = FETCH;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .stallD   (StallD),
        .flushD   (FlushD),
        .load     (done && !redirect),
        .instrF   (imem.rdata),
        .pcPlus4F (pcPlus4F),
        .InstrD   (InstrD),
        .PCPlus4D (PCPlus4D),
        .ValidD   (ValidD)
    );

endmodule

// File: tb/tb_fetch_stage_if_id.sv
// Directed bench for fetch_stage_if_id with an abstract request/response model checked every cycle.
module tb_fetch_stage_if_id;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        StallF, StallD, FlushD, PCSrcD, select_jumpD;
    logic [31:0] PCBranchD, PCJumpD;
    logic [31:0] InstrD, PCPlus4D;
    logic        ValidD;
    logic        readyDrv;

    int total = 0;
    int bad   = 0;

    // Memory stimulus: auto responder with a fixed number of wait states per request.
    bit autoReady  = 1'b1;
    int waitStates = 0;
    int waitCnt    = 0;

    // Model state: whether a request is active, the architectural PC, the address of the
    // outstanding request, whether that request is stale, and the expected IF/ID contents.
    bit          mActive;
    bit          mDrop;
    logic [31:0] mPc, mReqAddr, mInstr, mPc4;
    bit          mValid;

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h1000_0000 + a;
    endfunction

    fetch_stage_if_id_if imem ();

    assign imem.ready = readyDrv;
    assign imem.rdata = word(imem.addr);

    fetch_stage_if_id #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .StallF       (StallF),
        .StallD       (StallD),
        .FlushD       (FlushD),
        .PCSrcD       (PCSrcD),
        .PCBranchD    (PCBranchD),
        .select_jumpD (select_jumpD),
        .PCJumpD      (PCJumpD),
        .imem         (imem),
        .InstrD       (InstrD),
        .PCPlus4D     (PCPlus4D),
        .ValidD       (ValidD)
    );

    always @(posedge clk) begin
        assert (!(rst_n && StallD && !StallF))
        else $error("FAIL precondition: StallD=1 with StallF=0");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mActive  = 1'b0;
        mDrop    = 1'b0;
        mPc      = RESET_PC;
        mReqAddr = RESET_PC;
        mInstr   = NOP;
        mPc4     = 32'h0;
        mValid   = 1'b0;
    endtask

    // One clock edge of the abstract model, from the inputs present before the edge.
    task automatic modelEdge(input bit rdy);
        bit          redir, accept;
        logic [31:0] tgt;
        if (!rst_n) begin
            modelReset();
            return;
        end
        if (!mActive) begin
            mActive = 1'b1;
            if (!StallD) begin
                mInstr = NOP;
                mValid = 1'b0;
            end
            return;
        end
        redir  = (select_jumpD || PCSrcD) && !StallF;
        tgt    = select_jumpD ? PCJumpD : PCBranchD;
        accept = rdy && !mDrop && !StallF && !redir;
        if (!StallD) begin
            if (FlushD || !accept) begin
                mInstr = NOP;
                mValid = 1'b0;
            end else begin
                mInstr = word(mReqAddr);
                mPc4   = mReqAddr + 32'd4;
                mValid = 1'b1;
            end
        end
        if (redir) mPc = tgt;
        else if (accept) mPc = mPc + 32'd4;
        // Each completed response starts the next request at the current PC;
        // a redirect while a request is in flight makes that request stale.
        if (rdy) begin
            mReqAddr = mPc;
            mDrop    = 1'b0;
        end else if (redir) begin
            mDrop = 1'b1;
        end
    endtask

    task automatic checkModel();
        chk("imem_req",  {31'b0, imem.req}, {31'b0, mActive});
        chk("imem_addr", imem.addr, mReqAddr);
        chk("InstrD",    InstrD, mInstr);
        chk("PCPlus4D",  PCPlus4D, mPc4);
        chk("ValidD",    {31'b0, ValidD}, {31'b0, mValid});
    endtask

    // Called just after a falling edge; advances one full cycle.
    task automatic step();
        bit reqPre, rdyPre;
        if (autoReady) readyDrv = imem.req && (waitCnt >= waitStates);
        reqPre = imem.req;
        rdyPre = readyDrv;
        @(posedge clk);
        modelEdge(rdyPre);
        if (reqPre && rdyPre) waitCnt = 0;
        else if (reqPre) waitCnt++;
        #1;
        checkModel();
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        StallF       = 1'b0;
        StallD       = 1'b0;
        FlushD       = 1'b0;
        PCSrcD       = 1'b0;
        select_jumpD = 1'b0;
        PCBranchD    = 32'h0;
        PCJumpD      = 32'h0;
        readyDrv     = 1'b0;
        modelReset();
        @(negedge clk);
        checkModel();
        chk("reset req",   {31'b0, imem.req}, 32'd0);
        chk("reset addr",  imem.addr, 32'h0);
        chk("reset valid", {31'b0, ValidD}, 32'd0);

        // 1: zero-wait memory streams one instruction per cycle.
        rst_n = 1'b1;
        step();
        chk("t1 first addr", imem.addr, 32'h0);
        step();
        chk("t1 W0", InstrD, 32'h1000_0000);
        chk("t1 W0 pc4", PCPlus4D, 32'h4);
        steps(3);
        chk("t1 W3", InstrD, 32'h1000_000C);
        chk("t1 W3 pc4", PCPlus4D, 32'h10);
        chk("t1 next addr", imem.addr, 32'h10);

        // 2: three wait states per fetch.
        waitStates = 3;
        steps(3);
        chk("t2 addr held", imem.addr, 32'h10);
        step();
        chk("t2 instr", InstrD, 32'h1000_0010);
        chk("t2 valid", {31'b0, ValidD}, 32'd1);
        step();
        chk("t2 bubble", {31'b0, ValidD}, 32'd0);
        steps(3);
        chk("t2 instr2", InstrD, 32'h1000_0014);

        // 3: jump while a fetch is outstanding.
        step();
        select_jumpD = 1'b1;
        PCJumpD      = 32'h100;
        step();
        select_jumpD = 1'b0;
        chk("t3 old addr held", imem.addr, 32'h18);
        steps(2);
        chk("t3 new addr", imem.addr, 32'h100);
        chk("t3 no wrong path", {31'b0, ValidD}, 32'd0);
        steps(4);
        chk("t3 target instr", InstrD, 32'h1000_0100);
        chk("t3 target pc4", PCPlus4D, 32'h104);

        // 4: jump beats branch in the same cycle; flush gives a bubble.
        waitStates   = 0;
        PCSrcD       = 1'b1;
        PCBranchD    = 32'h40;
        select_jumpD = 1'b1;
        PCJumpD      = 32'h80;
        FlushD       = 1'b1;
        step();
        PCSrcD       = 1'b0;
        select_jumpD = 1'b0;
        FlushD       = 1'b0;
        chk("t4 jump addr", imem.addr, 32'h80);
        chk("t4 flush nop", InstrD, 32'h0);
        chk("t4 flush valid", {31'b0, ValidD}, 32'd0);
        step();
        chk("t4 jump instr", InstrD, 32'h1000_0080);

        // 5: two stall cycles then a flush.
        StallF = 1'b1;
        StallD = 1'b1;
        steps(2);
        chk("t5 instr held", InstrD, 32'h1000_0080);
        chk("t5 pc held", imem.addr, 32'h84);
        StallF = 1'b0;
        StallD = 1'b0;
        FlushD = 1'b1;
        step();
        FlushD = 1'b0;
        chk("t5 flush valid", {31'b0, ValidD}, 32'd0);
        chk("t5 pc4 held", PCPlus4D, 32'h84);

        // 6: reset in the middle of a discarded fetch.
        waitStates = 3;
        step();
        select_jumpD = 1'b1;
        PCJumpD      = 32'h200;
        step();
        select_jumpD = 1'b0;
        chk("t6 discard addr", imem.addr, 32'h88);
        rst_n = 1'b0;
        #1;
        modelReset();
        waitCnt = 0;
        checkModel();
        chk("t6 rst req", {31'b0, imem.req}, 32'd0);
        chk("t6 rst addr", imem.addr, RESET_PC);
        @(negedge clk);
        steps(2);
        autoReady = 1'b0;
        readyDrv  = 1'b1;
        rst_n     = 1'b1;
        step();
        chk("t6 idle ready ignored", {31'b0, ValidD}, 32'd0);
        autoReady  = 1'b1;
        waitStates = 0;
        step();
        chk("t6 restart instr", InstrD, 32'h1000_0000);
        chk("t6 restart pc4", PCPlus4D, 32'h4);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
